uart_word_tx: RTL and testbench

//   UART serializer: sends one DATA_WIDTH-bit word per frame on tx.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_word_tx_if.sv | 12 +
 rtl/uart_baud_counter.sv | 28 ++
 rtl/uart_word_tx.sv | 157 +++++++++++++++
 tb/tb_uart_word_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, idle line level and a baud divisor helper.
// No ports; imported by the TX serializer and the baud counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Rounded divisor from system clock to bit period.
    function automatic int unsigned clks_per_bit(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between the host TX FIFO pop side (master) and the serializer (slave).
// Signals: i_valid, i_data[DATA_WIDTH], i_ready.
interface uart_word_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_ready;

    modport master (output i_valid, output i_data, input i_ready);
    modport slave  (input i_valid, input i_data, output i_ready);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit timer: counts 0..CLKS_PER_BIT-1, bit_end high on the last cycle of each bit.
// Ports: sys_clk, rst (async high), restart (hold at 0), bit_end.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || bit_end) cnt_d = '0;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_word_tx.sv
// UART word serializer: start(0), data LSB first, optional even parity, stop bit(s).
// Ports: sys_clk, rst (async high), bus (slave: i_valid/i_data/i_ready),
//   tx (registered, idle high), o_busy (not IDLE), o_done (last cycle of final stop bit).
// Config macro UART_TX_HOLD_EN: one-entry holding register, frames chain with no idle gap.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PARITY_BIT   = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                sys_clk,
    input  logic                rst,
    uart_word_tx_if.slave       bus,
    output logic                tx,
    output logic                o_busy,
    output logic                o_done
);
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 2;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;

    logic                  bit_end;
    logic                  xfer;
    logic                  final_stop;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_word;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .sys_clk (sys_clk),
        .rst     (rst),
        .restart (state_q == S_IDLE),
        .bit_end (bit_end)
    );

`ifdef UART_TX_HOLD_EN
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    assign bus.i_ready = !hold_full_q;
`else
    assign bus.i_ready = (state_q == S_IDLE);
`endif

    assign xfer       = bus.i_valid && bus.i_ready;
    assign final_stop = (state_q == S_STOP) && bit_end
                        && (idx_q == IDX_W'(STOP_BITS - 1));
    assign tx         = tx_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = final_stop;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        par_d     = par_q;
        load_en   = (state_q == S_IDLE) && xfer;
        load_word = bus.i_data;
`ifdef UART_TX_HOLD_EN
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        // A queued word wins the final stop cycle; otherwise a word
        // arriving then bypasses the holding register entirely.
        if (final_stop) begin
            if (hold_full_q) begin
                load_en     = 1'b1;
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end else if (xfer) begin
                load_en = 1'b1;
            end
        end else if (xfer && state_q != S_IDLE) begin
            hold_d      = bus.i_data;
            hold_full_d = 1'b1;
        end
`endif
        unique case (state_q)
            S_IDLE: ;
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (final_stop)   state_d = S_IDLE;
                else if (bit_end) idx_d   = idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (load_en) begin
            state_d = S_START;
            shift_d = load_word;
            par_d   = ^load_word;
            idx_d   = '0;
        end
        // tx is registered, so it follows the state being entered.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_HOLD_EN
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
        end
    end
`endif
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: reset, frame contents, parity, back-to-back, reset mid-frame,
// and a no-parity two-stop-bit build. CLKS_PER_BIT=4, DATA_WIDTH=32.
module tb_uart_word_tx;
    localparam int CPB = 4;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    uart_word_tx_if #(.DATA_WIDTH(32)) bus_a ();
    uart_word_tx_if #(.DATA_WIDTH(32)) bus_b ();

    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    uart_word_tx #(
        .DATA_WIDTH(32), .PARITY_BIT(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)
    ) dut_a (
        .sys_clk(sys_clk), .rst(rst), .bus(bus_a),
        .tx(tx_a), .o_busy(busy_a), .o_done(done_a)
    );

    uart_word_tx #(
        .DATA_WIDTH(32), .PARITY_BIT(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)
    ) dut_b (
        .sys_clk(sys_clk), .rst(rst), .bus(bus_b),
        .tx(tx_b), .o_busy(busy_b), .o_done(done_b)
    );

    int   total = 0;
    int   bad   = 0;
    logic tx_s [1:400];
    logic dn_s [1:400];
    logic bz_s [1:400];
    logic rd_s [1:400];

    // Frame bit b: 0 start, 1..32 data LSB first, then parity (if any), then stop.
    function automatic logic exp_bit(input logic [31:0] w, input int b,
                                     input bit par_en, input logic p);
        if (b == 0)                 return 1'b0;
        if (b <= 32)                return w[b-1];
        if (par_en && b == 33)      return p;
        return 1'b1;
    endfunction

    task automatic capture(input bit selb, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge sys_clk);
            tx_s[k] = selb ? tx_b : tx_a;
            dn_s[k] = selb ? done_b : done_a;
            bz_s[k] = selb ? busy_b : busy_a;
            rd_s[k] = selb ? bus_b.i_ready : bus_a.i_ready;
            if (k == 1) begin
                bus_a.i_valid = 1'b0;
                bus_b.i_valid = 1'b0;
                bus_a.i_data  = ~bus_a.i_data;
                bus_b.i_data  = ~bus_b.i_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.i_valid = 1'b0; bus_a.i_data = '0;
        bus_b.i_valid = 1'b0; bus_b.i_data = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if (tx_a !== 1'b1) begin
            $display("FAIL reset_tx: got %b need 1", tx_a); bad++;
        end
        total++;
        if (bus_a.i_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b need 1", bus_a.i_ready); bad++;
        end
        total++;
        if (busy_a !== 1'b0) begin
            $display("FAIL reset_busy: got %b need 0", busy_a); bad++;
        end
        total++;
        if (done_a !== 1'b0) begin
            $display("FAIL reset_done: got %b need 0", done_a); bad++;
        end
        total++;
        if (tx_b !== 1'b1) begin
            $display("FAIL reset_tx_b: got %b need 1", tx_b); bad++;
        end
        rst = 1'b0;
    endtask

    task automatic test_frame(input bit selb, input logic [31:0] word,
                              input int stops, input bit par_en,
                              input logic exp_par, input string name);
        int   nb  = 1 + 32 + (par_en ? 1 : 0) + stops;
        int   len = nb * CPB;
        int   nd;
        bit   ok;
        bit   rdy = 1'b0;
        logic e;
        logic got;
        for (int w = 0; w < 400 && !rdy; w++) begin
            @(negedge sys_clk);
            rdy = selb ? bus_b.i_ready : bus_a.i_ready;
        end
        total++;
        if (!rdy) begin
            $display("FAIL %s ready_timeout: i_ready=0 need 1", name);
            bad++;
            return;
        end
        if (selb) begin bus_b.i_valid = 1'b1; bus_b.i_data = word; end
        else      begin bus_a.i_valid = 1'b1; bus_a.i_data = word; end
        @(posedge sys_clk);
        capture(selb, len + 4);
        for (int b = 0; b < nb; b++) begin
            e  = exp_bit(word, b, par_en, exp_par);
            ok = 1'b1;
            got = e;
            for (int c = 1; c <= CPB; c++)
                if (tx_s[b*CPB+c] !== e) begin ok = 1'b0; got = tx_s[b*CPB+c]; end
            total++;
            if (!ok) begin
                $display("FAIL %s bit%0d: tx=%b need %b", name, b, got, e);
                bad++;
            end
        end
        total++;
        if (dn_s[len] !== 1'b1) begin
            $display("FAIL %s done_at_%0d: got %b need 1", name, len, dn_s[len]);
            bad++;
        end
        nd = 0;
        for (int k = 1; k <= len + 4; k++) if (dn_s[k] === 1'b1) nd++;
        total++;
        if (nd != 1) begin
            $display("FAIL %s done_pulses: got %0d need 1", name, nd); bad++;
        end
        total++;
        if (bz_s[1] !== 1'b1 || bz_s[len+1] !== 1'b0) begin
            $display("FAIL %s busy: got %b/%b need 1/0", name, bz_s[1], bz_s[len+1]);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1 = 32'hA5A5A5A5;
        logic [31:0] w2 = 32'h3C3C3C3D;
        int   acc_k = 0;
        int   exp_acc, s2;
        logic exp_rd20, exp_gap;
        bit   ok;
        logic e;
`ifdef UART_TX_HOLD_EN
        exp_acc = 20; s2 = 141; exp_rd20 = 1'b1; exp_gap = 1'b0;
`else
        exp_acc = 141; s2 = 142; exp_rd20 = 1'b0; exp_gap = 1'b1;
`endif
        @(negedge sys_clk);
        bus_a.i_valid = 1'b1; bus_a.i_data = w1;
        @(posedge sys_clk);
        for (int k = 1; k <= 300; k++) begin
            @(negedge sys_clk);
            tx_s[k] = tx_a; dn_s[k] = done_a; rd_s[k] = bus_a.i_ready;
            if (k == 1) bus_a.i_valid = 1'b0;
            if (k == 20) begin bus_a.i_valid = 1'b1; bus_a.i_data = w2; end
            if (bus_a.i_valid && bus_a.i_ready && acc_k == 0) acc_k = k;
            else if (acc_k != 0 && bus_a.i_valid) begin
                bus_a.i_valid = 1'b0; bus_a.i_data = 32'h0;
            end
        end
        total++;
        if (rd_s[20] !== exp_rd20) begin
            $display("FAIL b2b_ready20: got %b need %b", rd_s[20], exp_rd20); bad++;
        end
        total++;
        if (acc_k != exp_acc) begin
            $display("FAIL b2b_accept_cycle: got %0d need %0d", acc_k, exp_acc); bad++;
        end
        total++;
        if (dn_s[140] !== 1'b1) begin
            $display("FAIL b2b_done1: got %b need 1", dn_s[140]); bad++;
        end
        total++;
        if (tx_s[141] !== exp_gap) begin
            $display("FAIL b2b_tx141: got %b need %b", tx_s[141], exp_gap); bad++;
        end
        ok = 1'b1;
        for (int b = 0; b < 35; b++) begin
            e = exp_bit(w1, b, 1'b1, 1'b0);
            for (int c = 1; c <= CPB; c++) if (tx_s[b*CPB+c] !== e) ok = 1'b0;
        end
        total++;
        if (!ok) begin $display("FAIL b2b_frame1: tx=bad need A5A5A5A5 frame"); bad++; end
        for (int b = 0; b < 35; b++) begin
            e  = exp_bit(w2, b, 1'b1, 1'b1);
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) if (tx_s[s2+b*CPB+c] !== e) ok = 1'b0;
            total++;
            if (!ok) begin
                $display("FAIL b2b_frame2_bit%0d: tx=%b need %b", b, tx_s[s2+b*CPB], e);
                bad++;
            end
        end
        total++;
        if (dn_s[s2+139] !== 1'b1) begin
            $display("FAIL b2b_done2: got %b need 1", dn_s[s2+139]); bad++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge sys_clk);
        bus_a.i_valid = 1'b1; bus_a.i_data = 32'hFFFFFBFF;
        @(posedge sys_clk);
        for (int k = 1; k <= 46; k++) begin
            @(negedge sys_clk);
            if (k == 1) bus_a.i_valid = 1'b0;
        end
        total++;
        if (tx_a !== 1'b0) begin
            $display("FAIL mid_bit10: got %b need 0", tx_a); bad++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.i_ready !== 1'b1) begin
            $display("FAIL mid_reset: tx/busy/ready=%b%b%b need 101",
                     tx_a, busy_a, bus_a.i_ready);
            bad++;
        end
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        test_frame(1'b0, 32'h00000001, 1, 1'b1, 1'b1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, 32'h12345678, 1, 1'b1, 1'b1, "w12345678");
        test_frame(1'b0, 32'hFFFFFFFF, 1, 1'b1, 1'b0, "wFFFFFFFF");
        test_frame(1'b0, 32'h00000000, 1, 1'b1, 1'b0, "w00000000");
        test_back_to_back();
        test_reset_mid();
        test_frame(1'b1, 32'hF0F0F0F0, 2, 1'b0, 1'b0, "nopar_2stop");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
